axi_lite_reg_selftest: RTL and testbench

Synthesizable AXI4-Lite master that runs a parametrised write/read-back register self-test against any AXI4-Lite slave peripheral (e.g. the SHA-512 core's register bank). It generates NUM_VECTORS data patterns and writes each to consecutive addresses. It reads every location back and compares it against the written value. It counts failing vectors and records the first failing address. It replaces the fixed 4-vector simulation-only BFM sequence with an in-fabric block usable in simulation and on silicon.

---
 rtl/axi_lite_reg_selftest.sv | 160 ++++++++++++++++
 tb/tb_axi_lite_reg_selftest.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_selftest.sv
// axi_lite_reg_selftest: AXI4-Lite master that writes NUM_VECTORS patterns, reads them back and counts mismatches.
// Optional watchdog on every awaited handshake is enabled by defining SELFTEST_TIMEOUT_EN.
module axi_lite_reg_selftest #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_VECTORS = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ADDR_STRIDE = 4,
  parameter logic [31:0] PATTERN_SEED = 32'h0101FFFF,
  parameter logic [31:0] PATTERN_INC = 32'h00010001,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic start,
  output logic busy,
  output logic done,
  output logic pass,
  output logic timeout,
  output logic [8:0] err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] first_err_addr,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0] M_AXI_AWPROT,
  output logic M_AXI_AWVALID,
  input  logic M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic M_AXI_WVALID,
  input  logic M_AXI_WREADY,
  input  logic [1:0] M_AXI_BRESP,
  input  logic M_AXI_BVALID,
  output logic M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0] M_AXI_ARPROT,
  output logic M_AXI_ARVALID,
  input  logic M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0] M_AXI_RRESP,
  input  logic M_AXI_RVALID,
  output logic M_AXI_RREADY
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, DONE} state_t;
  state_t state;
  logic [7:0] i;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic vfail, to_fire, wr_done, rd_fail, last;
  assign M_AXI_AWADDR = addr;
  assign M_AXI_ARADDR = addr;
  assign M_AXI_WDATA = data;
  assign M_AXI_WSTRB = '1;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign busy = (state != IDLE) && (state != DONE);
  // a channel whose VALID already dropped has completed its handshake
  assign wr_done = (~M_AXI_AWVALID | M_AXI_AWREADY) & (~M_AXI_WVALID | M_AXI_WREADY);
  assign rd_fail = vfail | (M_AXI_RRESP != 2'b00) | (M_AXI_RDATA != data);
  assign last = i == 8'(NUM_VECTORS - 1);
`ifdef SELFTEST_TIMEOUT_EN
  logic [15:0] tcnt;
  logic hs;
  always_comb hs = state == WR ? wr_done : state == WB ? M_AXI_BVALID : state == RA ? M_AXI_ARREADY : state == RD ? M_AXI_RVALID : 1'b0;
  assign to_fire = busy & ~hs & (tcnt == 16'(TIMEOUT_CYCLES));
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= (busy & ~hs) ? tcnt + 16'd1 : '0;
      timeout <= (!busy && start) ? 1'b0 : timeout | to_fire;
    end
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      state <= IDLE;
      i <= '0;
      addr <= '0;
      data <= '0;
      vfail <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      first_err_addr <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
    end else if (to_fire) begin
      state <= DONE;
      done <= 1'b1;
      pass <= 1'b0;
      err_count <= err_count + 9'd1;
      if (err_count == '0) first_err_addr <= addr;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= WR;
          i <= '0;
          addr <= BASE_ADDR;
          data <= DW'(PATTERN_SEED);
          done <= 1'b0;
          pass <= 1'b0;
          err_count <= '0;
          first_err_addr <= '0;
          M_AXI_AWVALID <= 1'b1;
          M_AXI_WVALID <= 1'b1;
        end
        WR: begin
          M_AXI_AWVALID <= M_AXI_AWVALID & ~M_AXI_AWREADY;
          M_AXI_WVALID <= M_AXI_WVALID & ~M_AXI_WREADY;
          if (wr_done) begin
            state <= WB;
            M_AXI_BREADY <= 1'b1;
          end
        end
        WB: if (M_AXI_BVALID) begin
          vfail <= M_AXI_BRESP != 2'b00;
          M_AXI_BREADY <= 1'b0;
          M_AXI_ARVALID <= 1'b1;
          state <= RA;
        end
        RA: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY <= 1'b1;
          state <= RD;
        end
        RD: if (M_AXI_RVALID) begin
          M_AXI_RREADY <= 1'b0;
          if (rd_fail) begin
            err_count <= err_count + 9'd1;
            if (err_count == '0) first_err_addr <= addr;
          end
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            pass <= ~rd_fail & (err_count == '0);
          end else begin
            state <= WR;
            i <= i + 8'd1;
            addr <= addr + AW'(ADDR_STRIDE);
            data <= data + DW'(PATTERN_INC);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_axi_lite_reg_selftest.sv
// tb_axi_lite_reg_selftest: scoreboard bench with a configurable RAM slave driving axi_lite_reg_selftest.
module tb_axi_lite_reg_selftest;
  logic tb_ACLK = 1'b0, ARESET = 1'b1, start = 1'b0;
  logic busy, done, pass, timeout;
  logic [8:0] err_count;
  logic [31:0] first_err_addr, AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0] AWPROT, ARPROT;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0] BRESP, RRESP;
  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_reg_selftest dut (
    .ACLK(tb_ACLK), .ARESET(ARESET), .start(start), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  // slave behaviour knobs
  int aw_dly = 0;
  bit mis8 = 0, berr0 = 0, rerr0 = 0, blk_b4 = 0;
  logic [31:0] mem [16];
  logic aw_got, w_got;
  logic [31:0] aw_a, w_d;
  int aw_cnt;
  assign AWREADY = aw_cnt >= aw_dly;
  assign WREADY = 1'b1;
  assign ARREADY = 1'b1;

  always @(posedge tb_ACLK or posedge ARESET)
    if (ARESET) begin
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0;
      BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
    end else begin : slave
      logic ga, gw;
      logic [31:0] a, d, rd;
      ga = aw_got || (AWVALID && AWREADY);
      gw = w_got || (WVALID && WREADY);
      a = aw_got ? aw_a : AWADDR;
      d = w_got ? w_d : WDATA;
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      if (BVALID && BREADY) BVALID <= 1'b0;
      if (ga && gw) begin
        mem[a[5:2]] <= d;
        aw_got <= 1'b0;
        w_got <= 1'b0;
        if (!(blk_b4 && a == 32'h4)) begin
          BVALID <= 1'b1;
          BRESP <= (berr0 && a == 32'h0) ? 2'b10 : 2'b00;
        end
      end else begin
        if (AWVALID && AWREADY) begin aw_got <= 1'b1; aw_a <= AWADDR; end
        if (WVALID && WREADY) begin w_got <= 1'b1; w_d <= WDATA; end
      end
      if (ARVALID && ARREADY) begin
        rd = mem[ARADDR[5:2]];
        if (mis8 && ARADDR == 32'h8) rd[0] = 1'b0;
        if (rerr0 && ARADDR == 32'h0) rd[0] = ~rd[0];
        RDATA <= rd;
        RRESP <= (rerr0 && ARADDR == 32'h0) ? 2'b10 : 2'b00;
        RVALID <= 1'b1;
      end else if (RVALID && RREADY) RVALID <= 1'b0;
    end

  typedef struct {int err; logic [31:0] fa; bit ps; bit to; int lat; int naw;} res_t;
  localparam logic [31:0] EA [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  localparam logic [31:0] ED [4] = '{32'h0101FFFF, 32'h01030000, 32'h01040001, 32'h01050002};
  logic [31:0] exp_aw[$], exp_w[$];
  res_t exp_res[$];
  int n_chk = 0, n_bad = 0, n_res = 0, tgt = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a handshake or finishes a run
  int cyc = 0, t0 = 0, nb = 0, naw = 0, nw = 0;
  bit st_prev = 0, aw_hold = 0, done_q = 0;
  logic [31:0] aw_prev;
  initial forever begin : monitor
    res_t e;
    @(negedge tb_ACLK);
    cyc++;
    if (ARESET) begin
      st_prev = 0; aw_hold = 0; done_q = 0;
      continue;
    end
    if (st_prev) chk("restart_busy_done", {busy, done}, 2'b10);
    if (aw_hold) chk("awaddr_stable", {AWVALID, AWADDR}, {1'b1, aw_prev});
    aw_hold = AWVALID && !AWREADY;
    aw_prev = AWADDR;
    if (AWVALID) naw++;
    if (WVALID) nw++;
    if (BVALID && BREADY) nb++;
    if (AWVALID && AWREADY) begin
      chk("aw_expected", exp_aw.size() > 0, 1);
      if (exp_aw.size() > 0) chk("awaddr", AWADDR, exp_aw.pop_front());
    end
    if (WVALID && WREADY) begin
      chk("w_expected", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) chk("wdata", {WSTRB, WDATA}, {4'hF, exp_w.pop_front()});
    end
    if (done && !done_q) begin
      chk("res_expected", exp_res.size() > 0, 1);
      if (exp_res.size() > 0) begin
        e = exp_res.pop_front();
        chk("err_count", err_count, e.err);
        chk("first_err_addr", first_err_addr, e.fa);
        chk("pass", pass, e.ps);
        chk("timeout", timeout, e.to);
        if (e.lat >= 0) begin
          chk("done_latency", cyc - t0, e.lat);
          chk("b_handshakes", nb, 4);
          chk("awvalid_cycles", naw, e.naw);
          chk("wvalid_cycles", nw, 4);
        end
      end
      n_res++;
    end
    done_q = done;
    st_prev = start && !busy;
    if (st_prev) begin t0 = cyc; nb = 0; naw = 0; nw = 0; end
  end

  task automatic setup(int d, bit m, bit be, bit re, bit bb);
    aw_dly = d; mis8 = m; berr0 = be; rerr0 = re; blk_b4 = bb;
  endtask

  task automatic kick(int err, logic [31:0] fa, bit ps, bit to, int lat, int na);
    for (int k = 0; k < 4; k++) begin exp_aw.push_back(EA[k]); exp_w.push_back(ED[k]); end
    exp_res.push_back('{err, fa, ps, to, lat, na});
    @(posedge tb_ACLK); #1 start = 1'b1;
    @(posedge tb_ACLK); #1 start = 1'b0;
  endtask

  task automatic wait_res(int lim);
    int k = 0;
    tgt++;
    while (n_res < tgt && k < lim) begin @(posedge tb_ACLK); k++; end
    chk("done_seen", n_res >= tgt, 1);
    @(posedge tb_ACLK); #1;
  endtask

  task automatic flush_reset();
    ARESET = 1'b1;
    exp_aw.delete(); exp_w.delete(); exp_res.delete();
    repeat (2) @(posedge tb_ACLK);
    #1 ARESET = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge tb_ACLK);
    #1;
    chk("rst_status", {busy, done, pass, timeout, err_count}, 0);
    chk("rst_first_err_addr", first_err_addr, 0);
    chk("rst_axi", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 0);
    ARESET = 1'b0;
    setup(0, 0, 0, 0, 0); kick(0, 32'h0, 1, 0, 17, 4); wait_res(100);
    chk("idle_axi_after_done", {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy}, 0);
    setup(3, 0, 0, 0, 0); kick(0, 32'h0, 1, 0, 29, 16); wait_res(200);
    setup(0, 1, 0, 0, 0); kick(1, 32'h8, 0, 0, 17, 4); wait_res(100);
    setup(0, 0, 1, 1, 0); kick(1, 32'h0, 0, 0, 17, 4); wait_res(100);
    setup(0, 0, 0, 0, 0); kick(0, 32'h0, 1, 0, 17, 4);
    begin : mid_reset
      int k = 0;
      while (!(ARVALID && ARADDR == 32'h8) && k < 100) begin @(posedge tb_ACLK); #1; k++; end
      chk("arvalid_v2_seen", ARVALID && ARADDR == 32'h8, 1);
      ARESET = 1'b1;
      #1 chk("mid_reset_outputs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done}, 0);
      flush_reset();
    end
    kick(0, 32'h0, 1, 0, 17, 4); wait_res(100);
    setup(0, 0, 0, 0, 1);
`ifdef SELFTEST_TIMEOUT_EN
    kick(1, 32'h4, 0, 1, -1, 0);
    repeat (300) @(posedge tb_ACLK);
    #1 chk("stalled_b_outcome", {busy, done, timeout}, 3'b011);
    tgt++;
`else
    kick(0, 32'h0, 0, 0, -1, 0);
    repeat (300) @(posedge tb_ACLK);
    #1 chk("stalled_b_outcome", {busy, done, timeout, BREADY}, 4'b1001);
`endif
    flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
